// File: rtl/sp_ram_pkg.sv
// Shared definitions for sp_ram and its controller: FSM encoding and default bus widths.
package sp_ram_pkg;

    localparam int ADD_WD_DEF  = 4;
    localparam int DATA_WD_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/sp_ram_ctrl_stats.sv
// Wrapping read/write response counters; instantiated only when SP_RAM_CTRL_STATS_EN is defined.
module sp_ram_ctrl_stats (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_hs,
    input  logic        wr_hs,
    output logic [15:0] rd_cnt,
    output logic [15:0] wr_cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            if (rd_hs) rd_cnt <= rd_cnt + 16'd1;
            if (wr_hs) wr_cnt <= wr_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/sp_ram_ctrl.sv
// Single-outstanding valid/ready front end for sp_ram with a fixed read latency.
// Optional response statistics are enabled by defining SP_RAM_CTRL_STATS_EN.
module sp_ram_ctrl
    import sp_ram_pkg::*;
#(
    parameter int ADD_WD  = ADD_WD_DEF,
    parameter int DATA_WD = DATA_WD_DEF,
    parameter int RD_LAT  = 1,
    parameter int CNT_WD  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_rnw,
    input  logic [ADD_WD-1:0]  req_add,
    input  logic [DATA_WD-1:0] req_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_rnw,
    output logic [DATA_WD-1:0] rsp_rdata,
    output logic               ram_cs,
    output logic               ram_rnw,
    output logic [ADD_WD-1:0]  ram_add,
    output logic [DATA_WD-1:0] ram_wr_data,
    input  logic [DATA_WD-1:0] ram_rd_data
`ifdef SP_RAM_CTRL_STATS_EN
    ,
    output logic [15:0]        stat_rd_cnt,
    output logic [15:0]        stat_wr_cnt
`endif
);

    state_t            state;
    logic [CNT_WD-1:0] lat_cnt;

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rnw     <= 1'b0;
            rsp_rdata   <= '0;
            ram_cs      <= 1'b0;
            ram_rnw     <= 1'b1;
            ram_add     <= '0;
            ram_wr_data <= '0;
            lat_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        ram_cs      <= 1'b1;
                        ram_rnw     <= req_rnw;
                        ram_add     <= req_add;
                        ram_wr_data <= req_wdata;
                        req_ready   <= 1'b0;
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    // The RAM samples cs on this edge; address and data stay put.
                    ram_cs <= 1'b0;
                    if (ram_rnw) begin
                        lat_cnt <= CNT_WD'(RD_LAT);
                        state   <= WAIT;
                    end else begin
                        rsp_valid <= 1'b1;
                        rsp_rnw   <= 1'b0;
                        rsp_rdata <= '0;
                        state     <= RESP;
                    end
                end
                WAIT: begin
                    lat_cnt <= lat_cnt - CNT_WD'(1);
                    if (lat_cnt == CNT_WD'(1)) begin
                        rsp_rdata <= ram_rd_data;
                        rsp_valid <= 1'b1;
                        rsp_rnw   <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SP_RAM_CTRL_STATS_EN
    logic rsp_hs;
    assign rsp_hs = (state == RESP) && rsp_valid && rsp_ready;

    sp_ram_ctrl_stats u_stats (
        .clk    (clk),
        .rst_n  (rst_n),
        .rd_hs  (rsp_hs && rsp_rnw),
        .wr_hs  (rsp_hs && !rsp_rnw),
        .rd_cnt (stat_rd_cnt),
        .wr_cnt (stat_wr_cnt)
    );
`endif

endmodule

// File: tb/tb_sp_ram_ctrl.sv
// Scoreboard bench for sp_ram_ctrl driving a behavioural 16-entry RAM with 5 ns read delay.
module tb_sp_ram_ctrl;
    import sp_ram_pkg::*;

    localparam int ADD_WD  = 4;
    localparam int DATA_WD = 32;
    localparam int RD_LAT  = 1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic               req_rnw = 1'b0;
    logic [ADD_WD-1:0]  req_add = '0;
    logic [DATA_WD-1:0] req_wdata = '0;
    logic               rsp_valid;
    logic               rsp_ready = 1'b1;
    logic               rsp_rnw;
    logic [DATA_WD-1:0] rsp_rdata;
    logic               ram_cs;
    logic               ram_rnw;
    logic [ADD_WD-1:0]  ram_add;
    logic [DATA_WD-1:0] ram_wr_data;
    logic [DATA_WD-1:0] ram_rd_data = '0;
`ifdef SP_RAM_CTRL_STATS_EN
    logic [15:0]        stat_rd_cnt;
    logic [15:0]        stat_wr_cnt;
`endif

    sp_ram_ctrl #(
        .ADD_WD  (ADD_WD),
        .DATA_WD (DATA_WD),
        .RD_LAT  (RD_LAT),
        .CNT_WD  (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rnw     (req_rnw),
        .req_add     (req_add),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rnw     (rsp_rnw),
        .rsp_rdata   (rsp_rdata),
        .ram_cs      (ram_cs),
        .ram_rnw     (ram_rnw),
        .ram_add     (ram_add),
        .ram_wr_data (ram_wr_data),
        .ram_rd_data (ram_rd_data)
`ifdef SP_RAM_CTRL_STATS_EN
        ,
        .stat_rd_cnt (stat_rd_cnt),
        .stat_wr_cnt (stat_wr_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM: samples cs on posedge, read data valid 5 ns later.
    logic [DATA_WD-1:0] ram_mem [16];
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_rnw) ram_rd_data <= #5 ram_mem[ram_add];
            else         ram_mem[ram_add] <= ram_wr_data;
        end
    end

    typedef struct {
        logic               rnw;
        logic [DATA_WD-1:0] data;
    } exp_t;

    exp_t               sb[$];
    logic [DATA_WD-1:0] ref_mem [16];
    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int hs_cnt = 0;
    int cs_pulses = 0;
    int accepts = 0;
    bit prev_cs = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: cs pulse width and scoreboard pop on the cycle before each handshake edge.
    always @(negedge clk) begin
        exp_t e;
        if (ram_cs) begin
            check("cs_1cyc", 32'(prev_cs), 32'd0);
            if (!prev_cs) cs_pulses++;
        end
        prev_cs = ram_cs;
        if (rst_n && rsp_valid && rsp_ready) begin
            hs_cnt++;
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                e = sb.pop_front();
                check("rsp_rnw", 32'(rsp_rnw), 32'(e.rnw));
                check("rsp_rdata", rsp_rdata, e.data);
            end
        end
    end

    // Entered and left at posedge+1; pushes the expected response at the accept edge.
    task automatic send(input logic rnw, input logic [3:0] a, input logic [31:0] d,
                        input bit hold, output int acc_cyc);
        exp_t e;
        int   n;
        req_valid = 1'b1;
        req_rnw   = rnw;
        req_add   = a;
        req_wdata = d;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_to", 32'(req_ready), 32'd1);
        @(posedge clk);
        e.rnw  = rnw;
        e.data = rnw ? ref_mem[a] : '0;
        if (!rnw) ref_mem[a] = d;
        sb.push_back(e);
        accepts++;
        #1;
        acc_cyc = cyc;
        check("rdy_low_after_acc", 32'(req_ready), 32'd0);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int c);
        int n;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("rsp_valid_to", 32'(rsp_valid), 32'd1);
        c = cyc;
    endtask

    task automatic drain();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(sb.size() == 0 && req_ready) && n < 200);
        check("drain", 32'(sb.size() == 0 && req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int c;
        int h0;
        logic [31:0] bp_exp;

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rnw", 32'(rsp_rnw), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_ram_cs", 32'(ram_cs), 32'd0);
        check("rst_ram_rnw", 32'(ram_rnw), 32'd1);
        check("rst_ram_add", 32'(ram_add), 32'd0);
        check("rst_ram_wr_data", ram_wr_data, 32'd0);
`ifdef SP_RAM_CTRL_STATS_EN
        check("rst_stat_rd", 32'(stat_rd_cnt), 32'd0);
        check("rst_stat_wr", 32'(stat_wr_cnt), 32'd0);
`endif
        repeat (3) @(negedge clk);
        check("no_cs_idle", 32'(cs_pulses), 32'd0);
        @(posedge clk);
        #1;

        // Write then read with latency measured in edges including the accept edge.
        send(1'b0, 4'h3, 32'hDEAD_BEEF, 1'b0, acc);
        wait_rsp(c);
        check("wr_lat", 32'(c - acc + 1), 32'd2);
        drain();
        send(1'b1, 4'h3, 32'h0, 1'b0, acc);
        wait_rsp(c);
        check("rd_lat", 32'(c - acc + 1), 32'(2 + RD_LAT));
        check("rd_deadbeef", rsp_rdata, 32'hDEAD_BEEF);
        drain();

        // Preload and back-to-back reads with req_valid held high.
        for (int a = 0; a < 16; a++)
            send(1'b0, 4'(a), 32'(a * 32'h11), (a != 15), acc);
        drain();
        for (int a = 0; a < 16; a++)
            send(1'b1, 4'(a), 32'h0, (a != 15), acc);
        drain();

        // Response backpressure on a read of 0xA.
        bp_exp = ref_mem[4'hA];
        rsp_ready = 1'b0;
        send(1'b1, 4'hA, 32'h0, 1'b0, acc);
        wait_rsp(c);
        h0 = hs_cnt;
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rdata", rsp_rdata, bp_exp);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        drain();
        repeat (3) @(posedge clk);
        #1;
        check("bp_one_hs", 32'(hs_cnt - h0), 32'd1);

        // Asynchronous reset while waiting on read latency.
        send(1'b1, 4'h3, 32'h0, 1'b0, acc);
        @(posedge clk);
        #2;
        check("in_wait", 32'(dut.state), 32'(WAIT));
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("mid_rst_cs", 32'(ram_cs), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(1'b1, 4'h3, 32'h0, 1'b0, acc);
        wait_rsp(c);
        check("post_rst_rd3", rsp_rdata, 32'h33);
        drain();

`ifdef SP_RAM_CTRL_STATS_EN
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("stat_clr_rd", 32'(stat_rd_cnt), 32'd0);
        for (int i = 0; i < 3; i++)
            send(1'b0, 4'(i), 32'hA500_0000 + 32'(i), 1'b0, acc);
        for (int i = 0; i < 5; i++)
            send(1'b1, 4'(i), 32'h0, 1'b0, acc);
        drain();
        repeat (2) @(posedge clk);
        #1;
        check("stat_wr_cnt", 32'(stat_wr_cnt), 32'd3);
        check("stat_rd_cnt", 32'(stat_rd_cnt), 32'd5);
        force dut.u_stats.rd_cnt = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.u_stats.rd_cnt;
        send(1'b1, 4'h1, 32'h0, 1'b0, acc);
        drain();
        repeat (2) @(posedge clk);
        #1;
        check("stat_rd_wrap", 32'(stat_rd_cnt), 32'd0);
        check("stat_wr_hold", 32'(stat_wr_cnt), 32'd3);
`endif

        check("cs_per_accept", 32'(cs_pulses), 32'(accepts));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
